// File: rtl/lcd_bus_responder_if.sv
// Pin bundle of the 4-bit character-LCD write bus: E strobe, RS, RW and DB[7:4].
// The LCD controller drives it (master); the responder only observes it (slave).
interface lcd_bus_responder_if;
    logic       iLCD_Enabled;
    logic       iLCD_RegisterSelect;
    logic       iLCD_ReadWrite;
    logic [3:0] iLCD_Data;

    modport master (output iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data);
    modport slave  (input  iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data);
endinterface

// File: rtl/lcd_bus_responder.sv
// Receiving end of the 4-bit character-LCD write bus: init tracking, byte assembly, command
// decode, busy window and DDRAM address. Define LCD_TIMING_CHECK_EN to add E-width/gap/busy checks.
module lcd_bus_responder #(
    parameter int T_EHIGH  = 12,
    parameter int T_NIBBLE = 50,
    parameter int T_INIT1  = 205000,
    parameter int T_INIT2  = 5000,
    parameter int T_CMD    = 2000,
    parameter int T_CLEAR  = 82000
) (
    input  logic                      Clock,
    input  logic                      Reset,
    lcd_bus_responder_if.slave        bus,
    output logic                      oInitDone,
    output logic                      oByteValid,
    output logic [7:0]                oByte,
    output logic                      oByteIsData,
    output logic                      oCharWrite,
    output logic [6:0]                oCharAddr,
    output logic [6:0]                oDdramAddr,
    output logic                      oBusy,
    output logic                      oError,
    output logic [2:0]                oErrorCode
);

    typedef enum logic [2:0] {
        INIT_0   = 3'd0,
        INIT_1   = 3'd1,
        INIT_2   = 3'd2,
        INIT_3   = 3'd3,
        READY_HI = 3'd4,
        READY_LO = 3'd5
    } state_e;

    typedef logic [19:0] cnt_t;

    localparam cnt_t CMD_C   = cnt_t'(T_CMD);
    localparam cnt_t CLEAR_C = cnt_t'(T_CLEAR);

    // Address counter skips the unused holes between the two display lines.
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        if (a == 7'h27) return 7'h40;
        if (a == 7'h67) return 7'h00;
        return a + 7'd1;
    endfunction

    state_e     state_q, state_d;
    logic       e_q, e_d, e_prev_q, e_prev_d;
    logic       rs_q, rs_d, rw_q, rw_d;
    logic [3:0] db_q, db_d;
    logic       nib_rs_q, nib_rs_d, nib_rw_q, nib_rw_d;
    logic [3:0] nib_db_q, nib_db_d;
    logic [3:0] upper_q, upper_d;
    logic       init_done_q, init_done_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] asm_byte_q, asm_byte_d;
    logic       byte_is_data_q, byte_is_data_d;
    logic       char_write_q, char_write_d;
    logic [6:0] char_addr_q, char_addr_d;
    logic [6:0] ddram_addr_q, ddram_addr_d;
    cnt_t       busy_cnt_q, busy_cnt_d;
    logic       error_q, error_d;
    logic [2:0] error_code_q, error_code_d;

    logic       e_fall;
    logic       in_init;
    logic [3:0] exp_nib;
    logic       bad_init;
    logic       accept;
    logic [7:0] new_byte;
    logic       chk_short, chk_gap, chk_busy;

    assign e_fall   = e_prev_q & ~e_q;
    assign in_init  = (state_q == INIT_0) || (state_q == INIT_1) ||
                      (state_q == INIT_2) || (state_q == INIT_3);
    assign exp_nib  = (state_q == INIT_3) ? 4'h2 : 4'h3;
    assign bad_init = in_init && (nib_rs_q || (nib_db_q != exp_nib));
    assign accept   = e_fall && !nib_rw_q && !bad_init;
    assign new_byte = {upper_q, nib_db_q};

    // Pin stage: nibble fields are held from the last cycle the registered E was high.
    always_comb begin
        e_d      = bus.iLCD_Enabled;
        rs_d     = bus.iLCD_RegisterSelect;
        rw_d     = bus.iLCD_ReadWrite;
        db_d     = bus.iLCD_Data;
        e_prev_d = e_q;
        nib_rs_d = nib_rs_q;
        nib_rw_d = nib_rw_q;
        nib_db_d = nib_db_q;
        if (e_q) begin
            nib_rs_d = rs_q;
            nib_rw_d = rw_q;
            nib_db_d = db_q;
        end
    end

`ifdef LCD_TIMING_CHECK_EN
    localparam cnt_t EHIGH_C  = cnt_t'(T_EHIGH);
    localparam cnt_t NIBBLE_C = cnt_t'(T_NIBBLE);
    localparam cnt_t INIT1_C  = cnt_t'(T_INIT1);
    localparam cnt_t INIT2_C  = cnt_t'(T_INIT2);

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    cnt_t high_cnt_q, high_cnt_d;
    cnt_t since_cnt_q, since_cnt_d;
    logic gap_err_q, gap_err_d;
    logic busy_err_q, busy_err_d;
    logic e_rise;
    logic gap_short;

    assign e_rise = e_q & ~e_prev_q;

    // Required gap depends on which nibble the rising strobe is about to deliver.
    always_comb begin
        unique case (state_q)
            INIT_1:   gap_short = since_cnt_q < INIT1_C;
            INIT_2:   gap_short = since_cnt_q < INIT2_C;
            READY_LO: gap_short = since_cnt_q < NIBBLE_C;
            default:  gap_short = 1'b0;
        endcase
    end

    // Gap and busy violations are seen at E rise but reported with that strobe's fall.
    always_comb begin
        high_cnt_d = high_cnt_q;
        if (e_rise)
            high_cnt_d = cnt_t'(1);
        else if (e_q)
            high_cnt_d = sat_inc(high_cnt_q);
        since_cnt_d = e_fall ? '0 : sat_inc(since_cnt_q);
        gap_err_d   = gap_err_q;
        busy_err_d  = busy_err_q;
        if (e_fall) begin
            gap_err_d  = 1'b0;
            busy_err_d = 1'b0;
        end else if (e_rise) begin
            gap_err_d  = gap_short;
            busy_err_d = (busy_cnt_q != '0);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            high_cnt_q  <= '0;
            since_cnt_q <= '0;
            gap_err_q   <= 1'b0;
            busy_err_q  <= 1'b0;
        end else begin
            high_cnt_q  <= high_cnt_d;
            since_cnt_q <= since_cnt_d;
            gap_err_q   <= gap_err_d;
            busy_err_q  <= busy_err_d;
        end
    end

    assign chk_short = high_cnt_q < EHIGH_C;
    assign chk_gap   = gap_err_q;
    assign chk_busy  = busy_err_q;
`else
    assign chk_short = 1'b0;
    assign chk_gap   = 1'b0;
    assign chk_busy  = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset)
            state_q <= INIT_0;
        else
            state_q <= state_d;
    end

    // A read strobe leaves the sequence untouched; a bad init nibble restarts it.
    always_comb begin
        state_d = state_q;
        if (e_fall && !nib_rw_q) begin
            unique case (state_q)
                INIT_0:   state_d = bad_init ? INIT_0 : INIT_1;
                INIT_1:   state_d = bad_init ? INIT_0 : INIT_2;
                INIT_2:   state_d = bad_init ? INIT_0 : INIT_3;
                INIT_3:   state_d = bad_init ? INIT_0 : READY_HI;
                READY_HI: state_d = READY_LO;
                READY_LO: state_d = READY_HI;
                default:  state_d = INIT_0;
            endcase
        end
    end

    always_comb begin
        upper_d        = upper_q;
        init_done_d    = init_done_q;
        byte_valid_d   = 1'b0;
        asm_byte_d     = asm_byte_q;
        byte_is_data_d = byte_is_data_q;
        char_write_d   = 1'b0;
        char_addr_d    = char_addr_q;
        ddram_addr_d   = ddram_addr_q;
        busy_cnt_d     = (busy_cnt_q != '0) ? busy_cnt_q - cnt_t'(1) : '0;
        error_d        = 1'b0;
        error_code_d   = 3'd0;

        if (e_fall) begin
            if (bad_init && !nib_rw_q)
                error_code_d = 3'd1;
            else if (chk_short)
                error_code_d = 3'd2;
            else if (chk_gap)
                error_code_d = 3'd3;
            else if (chk_busy)
                error_code_d = 3'd4;
            else if (nib_rw_q)
                error_code_d = 3'd5;
            error_d = (error_code_d != 3'd0);
        end

        if (accept) begin
            unique case (state_q)
                INIT_2: busy_cnt_d = CMD_C;
                INIT_3: begin
                    busy_cnt_d  = CMD_C;
                    init_done_d = 1'b1;
                end
                READY_HI: upper_d = nib_db_q;
                READY_LO: begin
                    byte_valid_d   = 1'b1;
                    asm_byte_d     = new_byte;
                    byte_is_data_d = nib_rs_q;
                    busy_cnt_d     = CMD_C;
                    if (nib_rs_q) begin
                        char_write_d = 1'b1;
                        char_addr_d  = ddram_addr_q;
                        ddram_addr_d = addr_inc(ddram_addr_q);
                    end else if (new_byte == 8'h01 || new_byte == 8'h02 || new_byte == 8'h03) begin
                        ddram_addr_d = 7'h00;
                        busy_cnt_d   = CLEAR_C;
                    end else if (new_byte[7]) begin
                        ddram_addr_d = new_byte[6:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            e_q            <= 1'b0;
            e_prev_q       <= 1'b0;
            rs_q           <= 1'b0;
            rw_q           <= 1'b0;
            db_q           <= 4'h0;
            nib_rs_q       <= 1'b0;
            nib_rw_q       <= 1'b0;
            nib_db_q       <= 4'h0;
            upper_q        <= 4'h0;
            init_done_q    <= 1'b0;
            byte_valid_q   <= 1'b0;
            asm_byte_q     <= 8'h00;
            byte_is_data_q <= 1'b0;
            char_write_q   <= 1'b0;
            char_addr_q    <= 7'h00;
            ddram_addr_q   <= 7'h00;
            busy_cnt_q     <= '0;
            error_q        <= 1'b0;
            error_code_q   <= 3'd0;
        end else begin
            e_q            <= e_d;
            e_prev_q       <= e_prev_d;
            rs_q           <= rs_d;
            rw_q           <= rw_d;
            db_q           <= db_d;
            nib_rs_q       <= nib_rs_d;
            nib_rw_q       <= nib_rw_d;
            nib_db_q       <= nib_db_d;
            upper_q        <= upper_d;
            init_done_q    <= init_done_d;
            byte_valid_q   <= byte_valid_d;
            asm_byte_q     <= asm_byte_d;
            byte_is_data_q <= byte_is_data_d;
            char_write_q   <= char_write_d;
            char_addr_q    <= char_addr_d;
            ddram_addr_q   <= ddram_addr_d;
            busy_cnt_q     <= busy_cnt_d;
            error_q        <= error_d;
            error_code_q   <= error_code_d;
        end
    end

    assign oInitDone   = init_done_q;
    assign oByteValid  = byte_valid_q;
    assign oByte       = asm_byte_q;
    assign oByteIsData = byte_is_data_q;
    assign oCharWrite  = char_write_q;
    assign oCharAddr   = char_addr_q;
    assign oDdramAddr  = ddram_addr_q;
    assign oBusy       = (busy_cnt_q != '0);
    assign oError      = error_q;
    assign oErrorCode  = error_code_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: strobe-level reference model with per-cycle output compare,
// plus literal expectations on key outputs. Timing parameters are scaled down for run time.
module tb_lcd_bus_responder;

    localparam int T_EHIGH  = 12;
    localparam int T_NIBBLE = 50;
    localparam int T_INIT1  = 300;
    localparam int T_INIT2  = 100;
    localparam int T_CMD    = 40;
    localparam int T_CLEAR  = 400;

`ifdef LCD_TIMING_CHECK_EN
    localparam bit TIMING_ON = 1'b1;
`else
    localparam bit TIMING_ON = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       oInitDone, oByteValid, oByteIsData, oCharWrite, oBusy, oError;
    logic [7:0] oByte;
    logic [6:0] oCharAddr, oDdramAddr;
    logic [2:0] oErrorCode;

    lcd_bus_responder_if bus ();

    lcd_bus_responder #(
        .T_EHIGH (T_EHIGH),
        .T_NIBBLE(T_NIBBLE),
        .T_INIT1 (T_INIT1),
        .T_INIT2 (T_INIT2),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .bus        (bus),
        .oInitDone  (oInitDone),
        .oByteValid (oByteValid),
        .oByte      (oByte),
        .oByteIsData(oByteIsData),
        .oCharWrite (oCharWrite),
        .oCharAddr  (oCharAddr),
        .oDdramAddr (oDdramAddr),
        .oBusy      (oBusy),
        .oError     (oError),
        .oErrorCode (oErrorCode)
    );

    always #10 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        bit         bv;
        logic [7:0] b;
        bit         isd;
        bit         cw;
        logic [6:0] ca;
        int         code;
        bit         initdone;
        logic [6:0] addr;
        bit         bload;
        int         blen;
    } ev_t;

    ev_t evq[$];

    // Reference model state (strobe level)
    int         m_idx;
    bit         m_hi_pend;
    logic [3:0] m_hi;
    logic [6:0] m_addr;
    bit         m_init;
    int         m_bstart, m_blen, m_last_fall;

    // Expected persistent outputs, advanced by the compare process
    logic [7:0] exp_byte;
    bit         exp_isd, exp_init;
    logic [6:0] exp_ca, exp_addr;
    int         exp_bstart, exp_blen;
    bit         chk_en = 1'b0;

    task automatic model_reset();
        m_idx = 0; m_hi_pend = 0; m_hi = 4'h0; m_addr = 7'h00; m_init = 0;
        m_bstart = 0; m_blen = 0; m_last_fall = -1000000;
        exp_byte = 8'h00; exp_isd = 0; exp_init = 0; exp_ca = 7'h00; exp_addr = 7'h00;
        exp_bstart = 0; exp_blen = 0;
        evq.delete();
    endtask

    // One strobe: E rose right after edge r, fell right after edge f.
    task automatic model(input int r, input int f, input bit rs, input bit rw, input logic [3:0] db);
        ev_t ev;
        bit c1, c2, c3, c4;
        int gap;
        logic [7:0] b;
        ev.cyc = f + 2; ev.bv = 0; ev.b = 8'h00; ev.isd = 0; ev.cw = 0; ev.ca = 7'h00;
        ev.bload = 0; ev.blen = 0;
        c1 = 0;
        gap = r - m_last_fall - 1;
        c2 = TIMING_ON && ((f - r) < T_EHIGH);
        c3 = TIMING_ON && ((m_idx == 1 && gap < T_INIT1) || (m_idx == 2 && gap < T_INIT2) ||
                           (m_idx == 4 && m_hi_pend && gap < T_NIBBLE));
        c4 = TIMING_ON && (r + 1 >= m_bstart) && (r + 1 < m_bstart + m_blen);
        if (!rw) begin
            if (m_idx < 4) begin
                if (rs || db != ((m_idx == 3) ? 4'h2 : 4'h3)) begin
                    c1 = 1; m_idx = 0;
                end else begin
                    if (m_idx >= 2) begin ev.bload = 1; ev.blen = T_CMD; end
                    m_idx++;
                    if (m_idx == 4) m_init = 1;
                end
            end else if (!m_hi_pend) begin
                m_hi = db; m_hi_pend = 1;
            end else begin
                m_hi_pend = 0;
                b = {m_hi, db};
                ev.bv = 1; ev.b = b; ev.isd = rs; ev.bload = 1; ev.blen = T_CMD;
                if (rs) begin
                    ev.cw = 1; ev.ca = m_addr;
                    if (m_addr == 7'h27) m_addr = 7'h40;
                    else if (m_addr == 7'h67) m_addr = 7'h00;
                    else m_addr = m_addr + 7'd1;
                end else if (b >= 8'h01 && b <= 8'h03) begin
                    m_addr = 7'h00; ev.blen = T_CLEAR;
                end else if (b >= 8'h80) begin
                    m_addr = b[6:0];
                end
            end
        end
        ev.code = c1 ? 1 : c2 ? 2 : c3 ? 3 : c4 ? 4 : rw ? 5 : 0;
        if (ev.bload) begin m_bstart = f + 2; m_blen = ev.blen; end
        ev.initdone = m_init; ev.addr = m_addr;
        m_last_fall = f;
        evq.push_back(ev);
    endtask

    always @(negedge Clock) begin : cmp
        ev_t ev;
        bit ebv, ecw;
        int ecode;
        if (chk_en) begin
            ebv = 0; ecw = 0; ecode = 0;
            if (evq.size() != 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                ebv = ev.bv; ecw = ev.cw; ecode = ev.code;
                if (ev.bv) begin exp_byte = ev.b; exp_isd = ev.isd; end
                if (ev.cw) exp_ca = ev.ca;
                exp_addr = ev.addr; exp_init = ev.initdone;
                if (ev.bload) begin exp_bstart = cyc; exp_blen = ev.blen; end
            end
            check("oByteValid", int'(oByteValid), int'(ebv));
            check("oCharWrite", int'(oCharWrite), int'(ecw));
            check("oError", int'(oError), int'(ecode != 0));
            check("oErrorCode", int'(oErrorCode), ecode);
            check("oByte", int'(oByte), int'(exp_byte));
            check("oByteIsData", int'(oByteIsData), int'(exp_isd));
            check("oCharAddr", int'(oCharAddr), int'(exp_ca));
            check("oDdramAddr", int'(oDdramAddr), int'(exp_addr));
            check("oInitDone", int'(oInitDone), int'(exp_init));
            check("oBusy", int'(oBusy), int'(cyc >= exp_bstart && cyc < exp_bstart + exp_blen));
        end
    end

    // Event log for literal checks
    int         n_err = 0, n_bv = 0, last_err = 0;
    logic [6:0] cw_log[$];
    always @(negedge Clock) begin
        if (oError) begin n_err <= n_err + 1; last_err <= int'(oErrorCode); end
        if (oByteValid) n_bv <= n_bv + 1;
        if (oCharWrite) cw_log.push_back(oCharAddr);
    end

    task automatic strobe(input bit rs, input bit rw, input logic [3:0] db, input int high, input int gap);
        int r, f;
        @(posedge Clock); #2;
        bus.iLCD_RegisterSelect = rs;
        bus.iLCD_ReadWrite      = rw;
        bus.iLCD_Data           = db;
        bus.iLCD_Enabled        = 1'b1;
        r = cyc;
        repeat (high) @(posedge Clock);
        #2;
        bus.iLCD_Enabled = 1'b0;
        f = cyc;
        model(r, f, rs, rw, db);
        repeat (gap) @(posedge Clock);
    endtask

    task automatic send_byte(input bit rs, input logic [7:0] b, input int gap_after);
        strobe(rs, 1'b0, b[7:4], 20, 60);
        strobe(rs, 1'b0, b[3:0], 20, gap_after);
    endtask

    task automatic do_init();
        strobe(1'b0, 1'b0, 4'h3, 20, 310);
        strobe(1'b0, 1'b0, 4'h3, 20, 110);
        strobe(1'b0, 1'b0, 4'h3, 20, 60);
        strobe(1'b0, 1'b0, 4'h2, 20, 60);
    endtask

    task automatic reset_dut();
        @(posedge Clock); #2;
        chk_en = 1'b0;
        Reset  = 1'b1;
        bus.iLCD_Enabled = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        Reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(negedge Clock);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int e0, bv0;
        bus.iLCD_Enabled = 1'b0;
        bus.iLCD_RegisterSelect = 1'b0;
        bus.iLCD_ReadWrite = 1'b0;
        bus.iLCD_Data = 4'h0;
        reset_dut();
        check("reset_initdone", int'(oInitDone), 0);
        check("reset_busy", int'(oBusy), 0);
        check("reset_addr", int'(oDdramAddr), 0);
        check("reset_byte", int'(oByte), 0);

        // Init then function-set 0x28
        do_init();
        check("init_done_before_byte", int'(oInitDone), 1);
        send_byte(1'b0, 8'h28, 60);
        @(negedge Clock);
        check("first_byte", int'(oByte), 'h28);
        check("first_byte_count", n_bv, 1);
        check("first_no_error", n_err, 0);

        // Set address 0x26, write two chars across the line-1 end
        send_byte(1'b0, 8'hA6, 60);
        send_byte(1'b1, 8'h41, 60);
        send_byte(1'b1, 8'h42, 60);
        @(negedge Clock);
        check("char0_addr", int'(cw_log[0]), 'h26);
        check("char1_addr", int'(cw_log[1]), 'h27);
        check("addr_wrap_line2", int'(oDdramAddr), 'h40);
        send_byte(1'b0, 8'hE7, 60);
        send_byte(1'b1, 8'h5A, 60);
        @(negedge Clock);
        check("char_at_67", int'(oCharAddr), 'h67);
        check("addr_wrap_line1", int'(oDdramAddr), 'h00);

        // Clear, then strobe early into the busy window
        send_byte(1'b0, 8'h85, 60);
        send_byte(1'b0, 8'h01, 100);
        @(negedge Clock);
        check("clear_addr", int'(oDdramAddr), 0);
        check("clear_busy", int'(oBusy), 1);
        e0 = n_err;
        last_err = 0;
        send_byte(1'b0, 8'h0C, 450);
        @(negedge Clock);
        check("busy_err_count", n_err - e0, TIMING_ON ? 2 : 0);
        check("busy_err_code", last_err, TIMING_ON ? 4 : 0);

        // Bad first init nibble, then a good sequence
        reset_dut();
        check("reinit_done_cleared", int'(oInitDone), 0);
        last_err = 0;
        strobe(1'b0, 1'b0, 4'h2, 20, 60);
        @(negedge Clock);
        check("bad_init_code", last_err, 1);
        check("bad_init_not_done", int'(oInitDone), 0);
        do_init();
        @(negedge Clock);
        check("good_init_after_bad", int'(oInitDone), 1);

        // Short E high on an upper nibble
        last_err = 0;
        strobe(1'b0, 1'b0, 4'h3, 8, 60);
        strobe(1'b0, 1'b0, 4'h0, 20, 60);
        @(negedge Clock);
        check("short_e_code", last_err, TIMING_ON ? 2 : 0);
        check("short_e_byte", int'(oByte), 'h30);

        // Read strobe is ignored apart from code 5
        send_byte(1'b0, 8'h93, 60);
        last_err = 0;
        bv0 = n_bv;
        strobe(1'b0, 1'b1, 4'h8, 20, 60);
        @(negedge Clock);
        check("read_code", last_err, 5);
        check("read_no_byte", n_bv - bv0, 0);
        check("read_addr_kept", int'(oDdramAddr), 'h13);
        send_byte(1'b1, 8'h61, 60);
        @(negedge Clock);
        check("after_read_byte", int'(oByte), 'h61);

        // Reset with a pending upper nibble discards it
        strobe(1'b1, 1'b0, 4'h4, 20, 60);
        reset_dut();
        check("midbyte_reset_byte", int'(oByte), 0);
        check("midbyte_reset_init", int'(oInitDone), 0);
        check("midbyte_reset_addr", int'(oDdramAddr), 0);
        do_init();
        send_byte(1'b1, 8'h48, 60);
        @(negedge Clock);
        check("reinit_byte", int'(oByte), 'h48);
        check("reinit_char_addr", int'(cw_log[cw_log.size() - 1]), 0);
        check("queue_drained", evq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
